// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types, widths and helpers for the PUF response path
package puf_pkg;

  localparam int PUF_RESP_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    VOTE   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Width of a counter that must hold 0..num_samples inclusive.
  function automatic int cnt_w(input int num_samples);
    return $clog2(num_samples + 1);
  endfunction

  // Width of the byte index; a single-byte key still needs one bit.
  function automatic int idx_w(input int key_bytes);
    return (key_bytes > 1) ? $clog2(key_bytes) : 1;
  endfunction

  // Number of set bits in one response byte.
  function automatic logic [3:0] popcount8(input logic [PUF_RESP_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < PUF_RESP_W; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/puf_bit_vote.sv
// rtl/puf_bit_vote.sv - per-bit ones counter producing majority vote and instability flag
module puf_bit_vote
  import puf_pkg::*;
#(
  parameter int NUM_SAMPLES = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic add_i,
  input  logic bit_i,
  output logic vote_o,
  output logic unstable_o
);

  localparam int CW = cnt_w(NUM_SAMPLES);

  logic [CW-1:0] ones_q;
  logic [CW-1:0] ones_d;

  // Clear wins over add; otherwise count ones on accepted samples.
  always_comb begin
    ones_d = ones_q;
    if (clear_i) begin
      ones_d = '0;
    end else if (add_i && bit_i) begin
      ones_d = ones_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign vote_o     = (ones_q > CW'(NUM_SAMPLES / 2));
  assign unstable_o = (ones_q != '0) && (ones_q != CW'(NUM_SAMPLES));

endmodule

// File: rtl/puf_response_stabilizer.sv
// rtl/puf_response_stabilizer.sv - majority-vote PUF responses into a key word with valid/ack
module puf_response_stabilizer
  import puf_pkg::*;
#(
  parameter  int NUM_SAMPLES = 7,
  parameter  int KEY_BYTES   = 4,
  localparam int UCW         = $clog2(8 * KEY_BYTES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [PUF_RESP_W-1:0]   response_in_i,
  input  logic                    response_valid_i,
  output logic                    busy_o,
  output logic [8*KEY_BYTES-1:0]  key_o,
  output logic                    key_valid_o,
  input  logic                    key_ack_i,
  output logic [UCW-1:0]          unstable_count_o
);

  localparam int CW = cnt_w(NUM_SAMPLES);
  localparam int IW = idx_w(KEY_BYTES);

  state_e                  state_q;
  logic [CW-1:0]           sample_cnt_q;
  logic [IW-1:0]           byte_idx_q;
  logic [8*KEY_BYTES-1:0]  key_q;
  logic [UCW-1:0]          unstable_q;
  logic                    busy_q;
  logic                    key_valid_q;

  logic                    add_w;
  logic                    clear_w;
  logic [PUF_RESP_W-1:0]   vote_w;
  logic [PUF_RESP_W-1:0]   unstable_w;

  // Counters only move on accepted samples; VOTE empties them for the next byte.
  assign add_w   = (state_q == SAMPLE) && response_valid_i;
  assign clear_w = (state_q == VOTE);

  for (genvar i = 0; i < PUF_RESP_W; i++) begin : g_bit
    puf_bit_vote #(
      .NUM_SAMPLES (NUM_SAMPLES)
    ) u_bit_vote (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_w),
      .add_i      (add_w),
      .bit_i      (response_in_i[i]),
      .vote_o     (vote_w[i]),
      .unstable_o (unstable_w[i])
    );
  end

  // Control FSM with byte packing and instability accumulation; outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      byte_idx_q   <= '0;
      key_q        <= '0;
      unstable_q   <= '0;
      busy_q       <= 1'b0;
      key_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q      <= SAMPLE;
            busy_q       <= 1'b1;
            key_q        <= '0;
            unstable_q   <= '0;
            byte_idx_q   <= '0;
            sample_cnt_q <= '0;
          end
        end
        SAMPLE: begin
          if (response_valid_i) begin
            sample_cnt_q <= sample_cnt_q + CW'(1);
            if (sample_cnt_q == CW'(NUM_SAMPLES - 1)) begin
              state_q <= VOTE;
            end
          end
        end
        VOTE: begin
          for (int b = 0; b < KEY_BYTES; b++) begin
            if (byte_idx_q == IW'(b)) begin
              key_q[8*b +: 8] <= vote_w;
            end
          end
          unstable_q   <= unstable_q + UCW'(popcount8(unstable_w));
          sample_cnt_q <= '0;
          if (byte_idx_q == IW'(KEY_BYTES - 1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b1;
          end else begin
            byte_idx_q <= byte_idx_q + IW'(1);
            state_q    <= SAMPLE;
          end
        end
        DONE: begin
          if (key_ack_i) begin
            state_q     <= IDLE;
            key_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          key_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign key_o            = key_q;
  assign key_valid_o      = key_valid_q;
  assign unstable_count_o = unstable_q;

endmodule

// File: doc/puf_response_stabilizer.md
Name: puf_response_stabilizer

Overview:
- Sits directly downstream of the hybrid PUF top and consumes its 8-bit Response stream.
- Majority-votes each response bit over NUM_SAMPLES consecutive valid samples to suppress PUF noise.
- Packs KEY_BYTES voted bytes into a key word and presents it with a valid/ack handshake.
- Reports how many bits were unstable, meaning the bit did not read identically in every sample.

Parameters:
- NUM_SAMPLES, 7: samples per voted byte. Must be odd, range 3..15.
- KEY_BYTES, 4: voted bytes per key. Range 1..16.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  single-cycle pulse that begins key collection; honoured only in IDLE.
- Response_In  input  8  PUF response byte.
- Response_Valid  input  1  Response_In is a valid sample this cycle.
- Busy  output  1  high in SAMPLE and VOTE.
- Key  output  8*KEY_BYTES  assembled key; byte 0 in [7:0].
- Key_Valid  output  1  high in DONE.
- Key_Ack  input  1  consumer has taken Key.
- Unstable_Count  output  clog2(8*KEY_BYTES+1)  number of unstable bits in the current key.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE. Busy=0, Key_Valid=0, Key=0, Unstable_Count=0. Every per-bit counter, the sample counter and the byte index are cleared.
- A reset in any state, including mid-SAMPLE, aborts collection. No partial key is ever flagged valid.
- States: IDLE, SAMPLE, VOTE, DONE.
- IDLE:
  - Start=1 -> SAMPLE on the next edge.
  - On that same edge, clear Key, Unstable_Count and byte_idx.
- SAMPLE:
  - Each cycle with Response_Valid=1: ones_cnt[i] += Response_In[i] for i=0..7, and sample_cnt++.
  - Cycles with Response_Valid=0 leave all counts unchanged; gaps of any length are allowed.
  - The edge that accepts sample NUM_SAMPLES moves to VOTE.
- VOTE (exactly one cycle):
  - vote[i] = ones_cnt[i] > NUM_SAMPLES/2 (integer division).
  - unstable[i] = ones_cnt[i] != 0 && ones_cnt[i] != NUM_SAMPLES.
  - Key[8*byte_idx +: 8] <= vote.
  - Unstable_Count += popcount(unstable).
  - Clear ones_cnt and sample_cnt.
  - If byte_idx == KEY_BYTES-1 -> DONE; otherwise byte_idx++ and -> SAMPLE.
- DONE:
  - Key_Valid=1. Key and Unstable_Count are held stable.
  - Key_Ack=1 -> IDLE, and Key_Valid falls on that edge.
  - Key and Unstable_Count keep their values in IDLE until the next accepted Start.
- Start is ignored outside IDLE, including in DONE. Start and Key_Ack together in DONE -> IDLE only; a fresh Start is required.
- Response_Valid and Response_In are ignored outside SAMPLE.
- Key_Ack is ignored outside DONE.
- Widths:
  - ones_cnt and sample_cnt are clog2(NUM_SAMPLES+1) bits and never overflow.
  - byte_idx is clog2(KEY_BYTES) bits, minimum 1.
  - Unstable_Count cannot exceed 8*KEY_BYTES, so it needs no saturation.
- Latency with Response_Valid held at 1:
  - Start sampled at edge 0.
  - Key_Valid is high from edge 1+KEY_BYTES*(NUM_SAMPLES+1), which is edge 33 for the defaults.

Decomposition:
- Shared package puf_pkg:
  - state enum {IDLE, SAMPLE, VOTE, DONE}.
  - Width helper functions: cnt_w(NUM_SAMPLES) and idx_w(KEY_BYTES).
  - Constant PUF_RESP_W=8, also used by the PUF top.
- One sub-module, puf_bit_vote, instantiated 8 times.
  - Contents: per-bit ones counter with add, clear and hold controls.
  - Outputs: vote and unstable.
- The FSM, byte packing and popcount accumulation stay in puf_response_stabilizer.

Test Plan:
- Steady input: Response_In=8'hA5 constant, Response_Valid=1, pulse Start -> Key=32'hA5A5A5A5, Unstable_Count=0, Key_Valid rises at edge 33 after Start.
- Noise on bit 0: Response_In=8'h01 in 3 of each 7 samples, otherwise 8'h00 -> every byte votes 8'h00, Key=0, Unstable_Count=4. The 4-of-7 case -> Key=32'h01010101, Unstable_Count=4.
- Valid gaps: Response_Valid toggling 1/0, Response_In=8'h3C -> same Key=32'h3C3C3C3C, Key_Valid delayed by exactly the number of invalid cycles in SAMPLE.
- Handshake: hold Key_Ack=0 for 10 cycles in DONE -> Key_Valid and Key stay stable. Key_Ack=1 -> Key_Valid=0 next edge. Start during SAMPLE and during DONE -> no effect.
- Reset mid-operation: assert Reset=0 during byte 2 SAMPLE -> all outputs 0 immediately. A fresh Start gives a correct key with no residue of the aborted counts.
- Parameter corner: NUM_SAMPLES=3, KEY_BYTES=1, samples 8'hFF, 8'h0F, 8'hF0 -> Key=8'hFF, Unstable_Count=8, Key_Valid at edge 5.
